// File: rtl/muldiv_writeback_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_writeback_unit_if
// Brief    : Issue/write-back bundle between the core and the RV32M unit.
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_writeback_unit_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_BUS_WIDTH = 5
);

  logic                      start_i;
  logic [2:0]                funct3_i;
  logic [DATA_WIDTH-1:0]     rs1_data_i;
  logic [DATA_WIDTH-1:0]     rs2_data_i;
  logic [ADDR_BUS_WIDTH-1:0] rd_addr_i;
  logic                      busy_o;
  logic                      done_o;
  logic                      write_en_o;
  logic [ADDR_BUS_WIDTH-1:0] write_addr_o;
  logic [DATA_WIDTH-1:0]     write_data_o;

  // Core / decode side
  modport master (
    output start_i, funct3_i, rs1_data_i, rs2_data_i, rd_addr_i,
    input  busy_o, done_o, write_en_o, write_addr_o, write_data_o
  );

  // Multiply/divide unit side
  modport slave (
    input  start_i, funct3_i, rs1_data_i, rs2_data_i, rd_addr_i,
    output busy_o, done_o, write_en_o, write_addr_o, write_data_o
  );

endinterface
`default_nettype wire

// File: rtl/muldiv_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_writeback_unit
// Brief    : Iterative RV32M multiply/divide unit driving the register-file
//            write port. Optional macro MULDIV_FAST_MUL_EN: one-cycle multiply.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_writeback_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_BUS_WIDTH = 5,
  parameter int ITERATIONS     = 32
) (
  input logic                    clk_i,
  input logic                    reset_i,
  muldiv_writeback_unit_if.slave mdu
);

  localparam int CW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam int DW = DATA_WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  localparam logic [CW-1:0] c_LAST_STEP = CW'(ITERATIONS - 1);
  localparam logic [DW-1:0] c_ALL_ONES  = '1;
  localparam logic [DW-1:0] c_INT_MIN   = {1'b1, {(DW-1){1'b0}}};

  logic [1:0]                r_state;
  logic [1:0]                w_state_nxt;
  logic [CW-1:0]             r_count;
  logic [2:0]                r_funct3;
  logic [ADDR_BUS_WIDTH-1:0] r_rd;
  logic [DW-1:0]             r_a;
  logic [2*DW-1:0]           r_acc;
  logic [DW:0]               r_rem;
  logic                      r_neg_q;
  logic                      r_neg_r;
  logic                      r_bypass;
  logic [DW-1:0]             r_bypass_res;

  logic [2:0]    w_f3;
  logic [DW-1:0] w_rs1;
  logic [DW-1:0] w_rs2;
  logic          w_is_div;
  logic          w_s1_signed;
  logic          w_s2_signed;
  logic          w_neg1;
  logic          w_neg2;
  logic [DW-1:0] w_mag1;
  logic [DW-1:0] w_mag2;
  logic          w_div_zero;
  logic          w_div_ovf;
  logic          w_bypass;
  logic [DW-1:0] w_bypass_res;

  assign w_f3  = mdu.funct3_i;
  assign w_rs1 = mdu.rs1_data_i;
  assign w_rs2 = mdu.rs2_data_i;

  // ---------------------------------------------------------------- decode
  always_comb begin
    w_is_div    = w_f3[2];
    w_s1_signed = (w_f3 == 3'b001) || (w_f3 == 3'b010) ||
                  (w_f3 == 3'b100) || (w_f3 == 3'b110);
    w_s2_signed = (w_f3 == 3'b001) || (w_f3 == 3'b100) || (w_f3 == 3'b110);
    w_neg1      = w_s1_signed & w_rs1[DW-1];
    w_neg2      = w_s2_signed & w_rs2[DW-1];
    w_mag1      = w_neg1 ? (DW'(0) - w_rs1) : w_rs1;
    w_mag2      = w_neg2 ? (DW'(0) - w_rs2) : w_rs2;
    w_div_zero  = w_is_div && (w_rs2 == '0);
    w_div_ovf   = w_is_div && !w_f3[0] && (w_rs1 == c_INT_MIN) && (w_rs2 == c_ALL_ONES);
  end

`ifdef MULDIV_FAST_MUL_EN
  // 33x33 signed product, formed over operands sign-extended to 64 bits
  logic [2*DW-1:0] w_fast_op1;
  logic [2*DW-1:0] w_fast_op2;
  logic [2*DW-1:0] w_fast_prod;

  assign w_fast_op1  = {{DW{w_neg1}}, w_rs1};
  assign w_fast_op2  = {{DW{w_neg2}}, w_rs2};
  assign w_fast_prod = w_fast_op1 * w_fast_op2;
`endif

  // Results known in the capture cycle skip the iterative datapath
  always_comb begin
    w_bypass     = w_div_zero || w_div_ovf;
    w_bypass_res = '0;
    if (w_div_zero) begin
      w_bypass_res = w_f3[1] ? w_rs1 : c_ALL_ONES;
    end else if (w_div_ovf) begin
      w_bypass_res = w_f3[1] ? '0 : c_INT_MIN;
    end
`ifdef MULDIV_FAST_MUL_EN
    if (!w_is_div) begin
      w_bypass     = 1'b1;
      w_bypass_res = (w_f3[1:0] == 2'b00) ? w_fast_prod[DW-1:0] : w_fast_prod[2*DW-1:DW];
    end
`endif
  end

  // ------------------------------------------------------------ step logic
  logic [DW:0]   w_mul_sum;
  logic [DW:0]   w_div_shift;
  logic [DW:0]   w_div_trial;
  logic          w_div_borrow;
  logic          w_unused_rem_msb;

  always_comb begin
    w_mul_sum    = {1'b0, r_acc[2*DW-1:DW]} + (r_acc[0] ? {1'b0, r_a} : '0);
    w_div_shift  = {r_rem[DW-1:0], r_acc[DW-1]};
    w_div_borrow = (w_div_shift < {1'b0, r_a});
    w_div_trial  = w_div_shift - {1'b0, r_a};
  end

  // Partial remainder never reaches the divisor, so its top bit stays clear
  assign w_unused_rem_msb = r_rem[DW];

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (mdu.start_i) begin
          w_state_nxt = w_bypass ? S_WRITE : S_CALC;
        end
      end
      S_CALC: begin
        if (r_count == c_LAST_STEP) begin
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------- datapath
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_count      <= '0;
      r_funct3     <= '0;
      r_rd         <= '0;
      r_a          <= '0;
      r_acc        <= '0;
      r_rem        <= '0;
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
      r_bypass     <= 1'b0;
      r_bypass_res <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mdu.start_i) begin
            r_count      <= '0;
            r_funct3     <= w_f3;
            r_rd         <= mdu.rd_addr_i;
            r_a          <= w_mag2;
            r_acc        <= {{DW{1'b0}}, w_mag1};
            r_rem        <= '0;
            r_neg_q      <= w_neg1 ^ w_neg2;
            r_neg_r      <= w_neg1;
            r_bypass     <= w_bypass;
            r_bypass_res <= w_bypass_res;
          end
        end
        S_CALC: begin
          r_count <= r_count + CW'(1);
          if (r_funct3[2]) begin
            r_rem            <= w_div_borrow ? w_div_shift : w_div_trial;
            r_acc[DW-1:0]    <= {r_acc[DW-2:0], ~w_div_borrow};
          end else begin
            r_acc <= {w_mul_sum, r_acc[DW-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------- result select
  logic [2*DW-1:0] w_prod;
  logic [DW-1:0]   w_quot;
  logic [DW-1:0]   w_remv;
  logic [DW-1:0]   w_result;

  always_comb begin
    w_prod = r_neg_q ? ((2*DW)'(0) - r_acc) : r_acc;
    w_quot = r_neg_q ? (DW'(0) - r_acc[DW-1:0]) : r_acc[DW-1:0];
    w_remv = r_neg_r ? (DW'(0) - r_rem[DW-1:0]) : r_rem[DW-1:0];
    if (r_bypass) begin
      w_result = r_bypass_res;
    end else begin
      case (r_funct3)
        3'b000:                 w_result = w_prod[DW-1:0];
        3'b001, 3'b010, 3'b011: w_result = w_prod[2*DW-1:DW];
        3'b100, 3'b101:         w_result = w_quot;
        default:                w_result = w_remv;
      endcase
    end
  end

  // --------------------------------------------------------------- outputs
  always_comb begin
    mdu.busy_o       = (r_state != S_IDLE);
    mdu.done_o       = 1'b0;
    mdu.write_en_o   = 1'b0;
    mdu.write_addr_o = '0;
    mdu.write_data_o = '0;
    if (r_state == S_WRITE) begin
      mdu.done_o       = 1'b1;
      mdu.write_en_o   = (r_rd != '0);
      mdu.write_addr_o = r_rd;
      mdu.write_data_o = w_result;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_writeback_unit
// Brief    : Directed-vector bench for muldiv_writeback_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_writeback_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  muldiv_writeback_unit_if #(.DATA_WIDTH(32), .ADDR_BUS_WIDTH(5)) mdu ();

  muldiv_writeback_unit #(
    .DATA_WIDTH    (32),
    .ADDR_BUS_WIDTH(5),
    .ITERATIONS    (32)
  ) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .mdu    (mdu)
  );

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_value({tag, ".busy_after"}, 32'(mdu.busy_o), 32'd0);
    check_value({tag, ".done_after"}, 32'(mdu.done_o), 32'd0);
    check_value({tag, ".we_after"}, 32'(mdu.write_en_o), 32'd0);
    check_value({tag, ".data_after"}, mdu.write_data_o, 32'd0);
  endtask

  // Called at a falling edge; the following rising edge is the capture edge N.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_data, input int exp_lat, input int restart_at);
    int lat;
    int busy_cnt;
    int extra_done;
    mdu.start_i    = 1'b1;
    mdu.funct3_i   = f3;
    mdu.rs1_data_i = a;
    mdu.rs2_data_i = b;
    mdu.rd_addr_i  = rd;
    @(negedge clk);
    mdu.start_i    = 1'b0;
    mdu.funct3_i   = 3'($urandom);
    mdu.rs1_data_i = $urandom;
    mdu.rs2_data_i = $urandom;
    mdu.rd_addr_i  = 5'($urandom);
    lat      = 0;
    busy_cnt = 0;
    for (int k = 1; k <= 45; k++) begin
      mdu.start_i = (k == restart_at);
      if (mdu.busy_o) busy_cnt++;
      if (mdu.done_o) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    mdu.start_i = 1'b0;
    check_value({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check_value({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
    check_value({tag, ".data"}, mdu.write_data_o, exp_data);
    check_value({tag, ".we"}, 32'(mdu.write_en_o), 32'(rd != 5'd0));
    check_value({tag, ".addr"}, 32'(mdu.write_addr_o), 32'(rd));
    @(negedge clk);
    check_idle(tag);
    if (restart_at != 0) begin
      extra_done = 0;
      for (int k = 0; k < 40; k++) begin
        if (mdu.done_o || mdu.write_en_o) extra_done++;
        @(negedge clk);
      end
      check_value({tag, ".extra_done"}, 32'(extra_done), 32'd0);
    end
  endtask

  initial begin
    int stray;
    rst            = 1'b1;
    mdu.start_i    = 1'b0;
    mdu.funct3_i   = '0;
    mdu.rs1_data_i = '0;
    mdu.rs2_data_i = '0;
    mdu.rd_addr_i  = '0;
    repeat (3) @(negedge clk);
    check_value("reset.busy", 32'(mdu.busy_o), 32'd0);
    check_value("reset.done", 32'(mdu.done_o), 32'd0);
    check_value("reset.we", 32'(mdu.write_en_o), 32'd0);
    check_value("reset.addr", 32'(mdu.write_addr_o), 32'd0);
    check_value("reset.data", mdu.write_data_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Multiplies
    run_op("mul_7x6",      3'b000, 32'd7,        32'd6,        5'd5,  32'd42,       MUL_LAT, 0);
    run_op("mul_m3x5",     3'b000, 32'hFFFFFFFD, 32'd5,        5'd6,  32'hFFFFFFF1, MUL_LAT, 0);
    run_op("mulh_m1xm1",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'h00000000, MUL_LAT, 0);
    run_op("mulhu_max",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, MUL_LAT, 0);
    run_op("mulhsu_m1x2",  3'b010, 32'hFFFFFFFF, 32'd2,        5'd3,  32'hFFFFFFFF, MUL_LAT, 0);
    run_op("mulh_minsq",   3'b001, 32'h80000000, 32'h80000000, 5'd4,  32'h40000000, MUL_LAT, 0);

    // Divides
    run_op("div_m7_2",     3'b100, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, DIV_LAT, 0);
    run_op("rem_m7_2",     3'b110, 32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, DIV_LAT, 0);
    run_op("div_7_m2",     3'b100, 32'd7,        32'hFFFFFFFE, 5'd9,  32'hFFFFFFFD, DIV_LAT, 0);
    run_op("rem_7_m2",     3'b110, 32'd7,        32'hFFFFFFFE, 5'd10, 32'd1,        DIV_LAT, 0);
    run_op("divu_100_7",   3'b101, 32'd100,      32'd7,        5'd11, 32'd14,       DIV_LAT, 0);
    run_op("remu_100_7",   3'b111, 32'd100,      32'd7,        5'd12, 32'd2,        DIV_LAT, 0);

    // Special cases
    run_op("divu_5_0",     3'b101, 32'd5,        32'd0,        5'd13, 32'hFFFFFFFF, 1, 0);
    run_op("rem_5_0",      3'b110, 32'd5,        32'd0,        5'd14, 32'd5,        1, 0);
    run_op("div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 1, 0);
    run_op("rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'd0,        1, 0);

    // rd = 0 with an ignored second start mid-operation
    run_op("divu_rd0",     3'b101, 32'd9,        32'd3,        5'd0,  32'd3,        DIV_LAT, 10);

    // Reset during a DIV
    mdu.start_i    = 1'b1;
    mdu.funct3_i   = 3'b100;
    mdu.rs1_data_i = 32'hFFFFFF9C;
    mdu.rs2_data_i = 32'd7;
    mdu.rd_addr_i  = 5'd20;
    @(negedge clk);
    mdu.start_i = 1'b0;
    stray = 0;
    for (int k = 1; k < 15; k++) begin
      if (mdu.done_o || mdu.write_en_o) stray++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_value("abort.stray_write", 32'(stray), 32'd0);
    check_value("abort.busy", 32'(mdu.busy_o), 32'd0);
    check_value("abort.done", 32'(mdu.done_o), 32'd0);
    check_value("abort.we", 32'(mdu.write_en_o), 32'd0);
    @(negedge clk);
    run_op("div_after_rst", 3'b100, 32'hFFFFFF9C, 32'd7,       5'd21, 32'hFFFFFFF2, DIV_LAT, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
`default_nettype wire
